// File: rtl/mp64_sram_pkg.sv
// Shared widths, words-per-row and clear-FSM encoding for the mixed-width SRAM controller.
package mp64_sram_pkg;

  localparam int ADDR_W_A_DEF = 4;
  localparam int DATA_W_A_DEF = 512;
  localparam int DATA_W_B_DEF = 64;
  localparam int WPR          = DATA_W_A_DEF / DATA_W_B_DEF;
  localparam int WPR_LOG2     = $clog2(WPR);
  localparam int CONF_CNT_W   = 16;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/mp64_rr_arb2.sv
// Two-way round-robin arbiter. The candidate is chosen without regard to hold,
// so the caller can inspect the candidate before deciding to stall it; a held
// cycle grants nobody and leaves the pointer where it was.
module mp64_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic hold,
  output logic cand_a,
  output logic cand_b,
  output logic gnt_a,
  output logic gnt_b
);

  // last_b = 1 means requester b won most recently, so a wins the next tie.
  logic last_b;

  // Pick the candidate: a sole requester wins, a tie goes to the one not granted last.
  always_comb begin
    cand_a = req_a & (~req_b | last_b);
    cand_b = req_b & (~req_a | ~last_b);
    gnt_a  = cand_a & ~hold;
    gnt_b  = cand_b & ~hold;
  end

  // Pointer moves only on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/mp64_sram_ctl.sv
// Controller for a dual-port SRAM: port A serves a wide tile requester and a
// row-clear engine; port B serves CPU and DMA word accesses, arbitrated round-robin.
// Handshake: a requester raises req with addr/we/wdata and holds them stable until
// gnt is seen high in the same cycle; a granted read returns rvalid/rdata exactly
// one cycle later, a granted write returns nothing.
module mp64_sram_ctl
  import mp64_sram_pkg::*;
#(
  parameter int ADDR_W_A = ADDR_W_A_DEF,
  parameter int DATA_W_A = DATA_W_A_DEF,
  parameter int DATA_W_B = DATA_W_B_DEF,
  parameter int ADDR_W_B = ADDR_W_A + $clog2(DATA_W_A / DATA_W_B)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  t_req,
  input  logic                  t_we,
  input  logic [ADDR_W_A-1:0]   t_addr,
  input  logic [DATA_W_A-1:0]   t_wdata,
  output logic                  t_gnt,
  output logic                  t_rvalid,
  output logic [DATA_W_A-1:0]   t_rdata,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_W_B-1:0]   c_addr,
  input  logic [DATA_W_B-1:0]   c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_W_B-1:0]   c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W_B-1:0]   d_addr,
  input  logic [DATA_W_B-1:0]   d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W_B-1:0]   d_rdata,
  input  logic                  clr_start,
  input  logic [ADDR_W_A-1:0]   clr_row,
  input  logic [ADDR_W_A:0]     clr_cnt,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [1:0]            clr_state,
  output logic [CONF_CNT_W-1:0] conflict_cnt,
  output logic                  sa_ce,
  output logic                  sa_we,
  output logic [ADDR_W_A-1:0]   sa_addr,
  output logic [DATA_W_A-1:0]   sa_wdata,
  input  logic [DATA_W_A-1:0]   sa_rdata,
  output logic                  sb_ce,
  output logic                  sb_we,
  output logic [ADDR_W_B-1:0]   sb_addr,
  output logic [DATA_W_B-1:0]   sb_wdata,
  input  logic [DATA_W_B-1:0]   sb_rdata
);

  localparam int WL = ADDR_W_B - ADDR_W_A;

  clr_state_t            state_q, state_d;
  logic [ADDR_W_A-1:0]   ptr_q, ptr_d;
  logic [ADDR_W_A:0]     rem_q, rem_d;
  logic                  clr_wr;

  logic                  cand_c, cand_d, conflict;
  logic [ADDR_W_A-1:0]   cand_row;
  logic                  cand_we;

  logic                  rv_t, rv_c, rv_d;
  logic [DATA_W_A-1:0]   t_rdata_q;
  logic [DATA_W_B-1:0]   c_rdata_q, d_rdata_q;

  // Clear FSM state register; reset abandons any clear in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // Clear FSM next state: one zero row per CLEAR cycle, row pointer wraps naturally.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    clr_wr  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          if (clr_cnt != '0) begin
            state_d = CLR_CLEAR;
            ptr_d   = clr_row;
            rem_d   = clr_cnt;
          end else begin
            state_d = CLR_DONE;
          end
        end
      end
      CLR_CLEAR: begin
        clr_wr = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W_A+1)'(1)) begin
          state_d = CLR_DONE;
        end
      end
      CLR_DONE: begin
        state_d = CLR_IDLE;
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  // Port A mux: clear writes own the port; otherwise the tile is granted on request.
  always_comb begin
    clr_busy  = (state_q != CLR_IDLE);
    clr_done  = (state_q == CLR_DONE);
    clr_state = state_q;
    t_gnt     = t_req & (state_q != CLR_CLEAR);
    if (clr_wr) begin
      sa_ce    = 1'b1;
      sa_we    = 1'b1;
      sa_addr  = ptr_q;
      sa_wdata = '0;
    end else begin
      sa_ce    = t_gnt;
      sa_we    = t_gnt & t_we;
      sa_addr  = t_gnt ? t_addr : '0;
      sa_wdata = (t_gnt & t_we) ? t_wdata : '0;
    end
  end

  // Row-level conflict between port A traffic and the narrow-port candidate.
  always_comb begin
    cand_row = cand_c ? c_addr[ADDR_W_B-1:WL] : d_addr[ADDR_W_B-1:WL];
    cand_we  = cand_c ? c_we : d_we;
    conflict = (cand_c | cand_d) & sa_ce & (cand_row == sa_addr) & (sa_we | cand_we);
  end

  mp64_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (c_req),
    .req_b  (d_req),
    .hold   (conflict),
    .cand_a (cand_c),
    .cand_b (cand_d),
    .gnt_a  (c_gnt),
    .gnt_b  (d_gnt)
  );

  // Port B mux driven by whichever narrow requester holds the grant.
  always_comb begin
    sb_ce    = c_gnt | d_gnt;
    sb_we    = (c_gnt & c_we) | (d_gnt & d_we);
    sb_addr  = c_gnt ? c_addr : (d_gnt ? d_addr : '0);
    sb_wdata = '0;
    if (c_gnt & c_we) begin
      sb_wdata = c_wdata;
    end else if (d_gnt & d_we) begin
      sb_wdata = d_wdata;
    end
  end

  // Read tags, saturating conflict counter and held copies of the last returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_t         <= 1'b0;
      rv_c         <= 1'b0;
      rv_d         <= 1'b0;
      conflict_cnt <= '0;
      t_rdata_q    <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      rv_t <= t_gnt & ~t_we;
      rv_c <= c_gnt & ~c_we;
      rv_d <= d_gnt & ~d_we;
      if (conflict && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
      if (rv_t) begin
        t_rdata_q <= sa_rdata;
      end
      if (rv_c) begin
        c_rdata_q <= sb_rdata;
      end
      if (rv_d) begin
        d_rdata_q <= sb_rdata;
      end
    end
  end

  // Return data is the SRAM output in the valid cycle, otherwise the last value returned.
  always_comb begin
    t_rvalid = rv_t;
    c_rvalid = rv_c;
    d_rvalid = rv_d;
    t_rdata  = rv_t ? sa_rdata : t_rdata_q;
    c_rdata  = rv_c ? sb_rdata : c_rdata_q;
    d_rdata  = rv_d ? sb_rdata : d_rdata_q;
  end

endmodule

// File: tb/tb_mp64_sram_ctl.sv
// Bench for mp64_sram_ctl: behavioural dual-port SRAM, directed stimulus,
// expected read data queued at grant time and checked by a separate monitor.
module tb_mp64_sram_ctl;

  logic         clk, rst_n;
  logic         t_req, t_we, t_gnt, t_rvalid;
  logic [3:0]   t_addr;
  logic [511:0] t_wdata, t_rdata;
  logic         c_req, c_we, c_gnt, c_rvalid;
  logic [6:0]   c_addr;
  logic [63:0]  c_wdata, c_rdata;
  logic         d_req, d_we, d_gnt, d_rvalid;
  logic [6:0]   d_addr;
  logic [63:0]  d_wdata, d_rdata;
  logic         clr_start, clr_busy, clr_done;
  logic [3:0]   clr_row;
  logic [4:0]   clr_cnt;
  logic [1:0]   clr_state;
  logic [15:0]  conflict_cnt;
  logic         sa_ce, sa_we;
  logic [3:0]   sa_addr;
  logic [511:0] sa_wdata, sa_rdata;
  logic         sb_ce, sb_we;
  logic [6:0]   sb_addr;
  logic [63:0]  sb_wdata, sb_rdata;

  logic [511:0] mem [16];
  logic         preload;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp_t_q[$];
  logic [63:0]  exp_c_q[$];
  logic [63:0]  exp_d_q[$];

  mp64_sram_ctl dut (
    .clk(clk), .rst_n(rst_n),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .clr_start(clr_start), .clr_row(clr_row), .clr_cnt(clr_cnt),
    .clr_busy(clr_busy), .clr_done(clr_done), .clr_state(clr_state),
    .conflict_cnt(conflict_cnt),
    .sa_ce(sa_ce), .sa_we(sa_we), .sa_addr(sa_addr), .sa_wdata(sa_wdata), .sa_rdata(sa_rdata),
    .sb_ce(sb_ce), .sb_we(sb_we), .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_rdata(sb_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [511:0] pat_row(input int r);
    logic [511:0] v;
    for (int w = 0; w < 8; w++) v[w*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(r*16 + w);
    return v;
  endfunction

  function automatic logic [511:0] fill_row(input logic [63:0] base);
    logic [511:0] v;
    for (int w = 0; w < 8; w++) v[w*64 +: 64] = base | 64'(w);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    t_req = 0; t_we = 0; t_addr = '0; t_wdata = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    clr_start = 0; clr_row = '0; clr_cnt = '0;
  endtask

  task automatic tile_read(input logic [3:0] row, input logic [511:0] exp);
    t_req = 1; t_we = 0; t_addr = row;
    exp_t_q.push_back(exp);
    @(negedge clk);
    chk("tile_read_gnt", t_gnt, 1);
    cyc();
    t_req = 0;
  endtask

  // ---------------- SRAM model (1-cycle read latency both ports) ----------------
  always @(posedge clk) begin
    if (preload) begin
      for (int r = 0; r < 16; r++) mem[r] <= pat_row(r);
    end else begin
      if (sa_ce) begin
        if (sa_we) mem[sa_addr] <= sa_wdata;
        else       sa_rdata <= mem[sa_addr];
      end
      if (sb_ce) begin
        if (sb_we) mem[sb_addr[6:3]][{sb_addr[2:0], 6'b0} +: 64] <= sb_wdata;
        else       sb_rdata <= mem[sb_addr[6:3]][{sb_addr[2:0], 6'b0} +: 64];
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [511:0] mon_t;
  logic [63:0]  mon_b;
  always @(negedge clk) begin
    if (rst_n) begin
      if (t_rvalid) begin
        n_checks++;
        if (exp_t_q.size() == 0) begin
          n_fail++;
          $display("FAIL t_rvalid_unexpected: got rvalid=1 want no pending tile read");
        end else begin
          mon_t = exp_t_q.pop_front();
          if (t_rdata !== mon_t) begin
            n_fail++;
            $display("FAIL t_rdata: got %h want %h", t_rdata, mon_t);
          end
        end
      end
      if (c_rvalid) begin
        n_checks++;
        if (exp_c_q.size() == 0) begin
          n_fail++;
          $display("FAIL c_rvalid_unexpected: got rvalid=1 want no pending cpu read");
        end else begin
          mon_b = exp_c_q.pop_front();
          if (c_rdata !== mon_b) begin
            n_fail++;
            $display("FAIL c_rdata: got %h want %h", c_rdata, mon_b);
          end
        end
      end
      if (d_rvalid) begin
        n_checks++;
        if (exp_d_q.size() == 0) begin
          n_fail++;
          $display("FAIL d_rvalid_unexpected: got rvalid=1 want no pending dma read");
        end else begin
          mon_b = exp_d_q.pop_front();
          if (d_rdata !== mon_b) begin
            n_fail++;
            $display("FAIL d_rdata: got %h want %h", d_rdata, mon_b);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [511:0] row4_mod;

  initial begin
    idle_all();
    rst_n = 0;
    preload = 1;
    repeat (3) @(posedge clk);
    #1;
    preload = 0;
    @(negedge clk);
    chk("rst_t_gnt", t_gnt, 0);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_rvalids", {t_rvalid, c_rvalid, d_rvalid}, 0);
    chk("rst_ces", {sa_ce, sb_ce}, 0);
    chk("rst_clr", {clr_busy, clr_done}, 0);
    chk("rst_clr_state", clr_state, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    chk("rst_rdata", {t_rdata[63:0] | c_rdata | d_rdata}, 0);
    cyc();
    rst_n = 1;
    cyc();

    // Tile write then read row 3
    t_req = 1; t_we = 1; t_addr = 4'd3; t_wdata = fill_row(64'hCAFE_0000_0000_0000);
    @(negedge clk);
    chk("twr_gnt", t_gnt, 1);
    chk("twr_sa", {sa_ce, sa_we, sa_addr}, {1'b1, 1'b1, 4'd3});
    cyc();
    t_we = 0; t_wdata = '0;
    exp_t_q.push_back(fill_row(64'hCAFE_0000_0000_0000));
    @(negedge clk);
    chk("trd_gnt", t_gnt, 1);
    chk("twr_no_rvalid", t_rvalid, 0);
    cyc();
    t_req = 0;
    @(negedge clk);
    chk("trd_rvalid", t_rvalid, 1);
    cyc();

    // CPU and DMA read together for 4 cycles: C,D,C,D
    c_req = 1; c_addr = 7'd19;   // row 2 word 3
    d_req = 1; d_addr = 7'd46;   // row 5 word 6
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_c_q.push_back(64'hA5A5_0000_0000_0023);
      else            exp_d_q.push_back(64'hA5A5_0000_0000_0056);
      @(negedge clk);
      chk("rr_c_gnt", c_gnt, (i % 2 == 0));
      chk("rr_d_gnt", d_gnt, (i % 2 == 1));
      chk("rr_sb_addr", sb_addr, (i % 2 == 0) ? 7'd19 : 7'd46);
      chk("rr_c_rvalid", c_rvalid, (i % 2 == 1));
      chk("rr_d_rvalid", d_rvalid, (i != 0) && (i % 2 == 0));
      cyc();
    end
    idle_all();
    @(negedge clk);
    chk("rr_last_d_rvalid", {c_rvalid, d_rvalid}, 2'b01);
    cyc();

    // Tile writes row 1 while CPU reads row 1 word 5
    t_req = 1; t_we = 1; t_addr = 4'd1; t_wdata = fill_row(64'hBEEF_0000_0000_0010);
    c_req = 1; c_addr = 7'd13;
    @(negedge clk);
    chk("cf1_t_gnt", t_gnt, 1);
    chk("cf1_c_gnt", c_gnt, 0);
    chk("cf1_sb_ce", sb_ce, 0);
    cyc();
    t_req = 0; t_we = 0; t_wdata = '0;
    exp_c_q.push_back(64'hBEEF_0000_0000_0015);
    @(negedge clk);
    chk("cf1_c_gnt_next", c_gnt, 1);
    chk("cf1_cnt", conflict_cnt, 1);
    cyc();
    idle_all();
    cyc();

    // Read/read on the same row is not a conflict
    t_req = 1; t_addr = 4'd2;
    d_req = 1; d_addr = 7'd16;   // row 2 word 0
    exp_t_q.push_back(pat_row(2));
    exp_d_q.push_back(64'hA5A5_0000_0000_0020);
    @(negedge clk);
    chk("rr_same_row_gnts", {t_gnt, d_gnt}, 2'b11);
    chk("rr_same_row_cnt", conflict_cnt, 1);
    cyc();
    idle_all();
    cyc();

    // Tile read vs DMA write on the same row is a conflict
    t_req = 1; t_addr = 4'd4;
    d_req = 1; d_we = 1; d_addr = 7'd33; d_wdata = 64'h1234_5678_9ABC_DEF0;
    exp_t_q.push_back(pat_row(4));
    @(negedge clk);
    chk("cf2_t_gnt", t_gnt, 1);
    chk("cf2_d_gnt", d_gnt, 0);
    cyc();
    t_req = 0;
    @(negedge clk);
    chk("cf2_d_gnt_next", d_gnt, 1);
    chk("cf2_sb_we", sb_we, 1);
    chk("cf2_cnt", conflict_cnt, 2);
    cyc();
    idle_all();
    @(negedge clk);
    chk("dwr_no_rvalid", d_rvalid, 0);
    cyc();
    row4_mod = pat_row(4);
    row4_mod[127:64] = 64'h1234_5678_9ABC_DEF0;
    tile_read(4'd4, row4_mod);
    cyc();

    // Held tie: pointer must not move while stalled
    t_req = 1; t_we = 1; t_addr = 4'd6; t_wdata = fill_row(64'hD00D_0000_0000_0060);
    c_req = 1; c_addr = 7'd48;   // row 6 word 0
    d_req = 1; d_addr = 7'd56;   // row 7 word 0
    @(negedge clk);
    chk("cf3_gnts", {c_gnt, d_gnt}, 2'b00);
    cyc();
    t_req = 0; t_we = 0; t_wdata = '0;
    exp_c_q.push_back(64'hD00D_0000_0000_0060);
    @(negedge clk);
    chk("cf3_c_wins", {c_gnt, d_gnt}, 2'b10);
    chk("cf3_cnt", conflict_cnt, 3);
    cyc();
    c_req = 0;
    exp_d_q.push_back(64'hA5A5_0000_0000_0070);
    @(negedge clk);
    chk("cf3_d_next", d_gnt, 1);
    cyc();
    idle_all();
    cyc();

    // Clear rows 14,15,0,1 with the tile requesting throughout
    clr_start = 1; clr_row = 4'd14; clr_cnt = 5'd4;
    @(negedge clk);
    chk("clr_start_busy", clr_busy, 0);
    chk("clr_start_sa_ce", sa_ce, 0);
    cyc();
    clr_start = 0;
    t_req = 1; t_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        clr_start = 1; clr_row = 4'd9; clr_cnt = 5'd0;
      end
      @(negedge clk);
      chk("clr_t_gnt", t_gnt, 0);
      chk("clr_busy", {clr_busy, clr_done}, 2'b10);
      chk("clr_sa", {sa_ce, sa_we, sa_addr}, {1'b1, 1'b1, 4'(14 + i)});
      chk("clr_wdata_zero", |sa_wdata, 0);
      cyc();
      clr_start = 0;
    end
    exp_t_q.push_back(pat_row(5));
    @(negedge clk);
    chk("clr_done_pulse", {clr_busy, clr_done}, 2'b11);
    chk("clr_done_t_gnt", t_gnt, 1);
    cyc();
    t_req = 0;
    @(negedge clk);
    chk("clr_back_idle", {clr_busy, clr_done}, 2'b00);
    cyc();
    tile_read(4'd15, '0);
    tile_read(4'd1, '0);
    tile_read(4'd13, pat_row(13));
    cyc();

    // Zero-length clear
    clr_start = 1; clr_row = 4'd7; clr_cnt = 5'd0;
    @(negedge clk);
    chk("clr0_start_sa_ce", sa_ce, 0);
    cyc();
    clr_start = 0;
    @(negedge clk);
    chk("clr0_done", {clr_busy, clr_done}, 2'b11);
    chk("clr0_sa_ce", sa_ce, 0);
    cyc();
    @(negedge clk);
    chk("clr0_idle", {clr_busy, clr_done}, 2'b00);
    cyc();

    // Reset in the middle of a clear of rows 8..11
    clr_start = 1; clr_row = 4'd8; clr_cnt = 5'd4;
    cyc();
    clr_start = 0;
    @(negedge clk);
    chk("clrr_row8", sa_addr, 4'd8);
    cyc();
    @(negedge clk);
    chk("clrr_row9", sa_addr, 4'd9);
    cyc();
    rst_n = 0;
    @(negedge clk);
    chk("clrr_busy_low", clr_busy, 0);
    chk("clrr_sa_ce_low", sa_ce, 0);
    chk("clrr_cnt_cleared", conflict_cnt, 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("clrr_no_done", {clr_busy, clr_done}, 2'b00);
      cyc();
    end
    tile_read(4'd9, '0);
    tile_read(4'd10, pat_row(10));
    tile_read(4'd11, pat_row(11));
    repeat (3) cyc();

    chk("t_queue_empty", exp_t_q.size(), 0);
    chk("c_queue_empty", exp_c_q.size(), 0);
    chk("d_queue_empty", exp_d_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp64_sram_ctl.md
MP64_SRAM_CTL -- requirements
Module: mp64_sram_ctl

Interface
REQ-001 Parameter ADDR_W_A, 4, row address width of the wide port.
REQ-002 Parameter DATA_W_A, 512, wide row width.
REQ-003 Parameter DATA_W_B, 64, narrow word width; words per row WPR = DATA_W_A/DATA_W_B (8).
REQ-004 Parameter ADDR_W_B, ADDR_W_A+log2(WPR) (7), narrow word address width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 t_req, t_we  in  1 each  tile requester request and write enable.
REQ-008 t_addr  in  ADDR_W_A; t_wdata  in  DATA_W_A  tile row address and write data.
REQ-009 t_gnt, t_rvalid  out  1 each; t_rdata  out  DATA_W_A  tile grant, read-data valid, read data.
REQ-010 c_req, c_we / d_req, d_we  in  1 each  CPU / DMA request and write enable.
REQ-011 c_addr, d_addr  in  ADDR_W_B; c_wdata, d_wdata  in  DATA_W_B  word address {row, word} and write data.
REQ-012 c_gnt, c_rvalid, d_gnt, d_rvalid  out  1 each; c_rdata, d_rdata  out  DATA_W_B.
REQ-013 clr_start  in  1; clr_row  in  ADDR_W_A; clr_cnt  in  ADDR_W_A+1  row-clear command.
REQ-014 clr_busy, clr_done  out  1 each  clear in progress; one-cycle completion pulse.
REQ-015 conflict_cnt  out  16  saturating count of stalled narrow-port cycles.
REQ-016 sa_ce, sa_we  out  1; sa_addr  out  ADDR_W_A; sa_wdata  out  DATA_W_A; sa_rdata  in  DATA_W_A  to SRAM port A.
REQ-017 sb_ce, sb_we  out  1; sb_addr  out  ADDR_W_B; sb_wdata  out  DATA_W_B; sb_rdata  in  DATA_W_B  to SRAM port B.

Function
REQ-018 SRAM has 1-cycle read latency on both ports; grants are combinational in the request cycle; requesters hold req/addr/we/wdata stable until granted.
REQ-019 Clear FSM states IDLE, CLEAR, DONE; IDLE+clr_start with clr_cnt!=0 -> CLEAR; clr_cnt==0 -> DONE directly with no writes; clr_start outside IDLE is ignored.
REQ-020 In CLEAR, one zero row per cycle is written via port A at (clr_row+i) mod 2^ADDR_W_A, i=0..clr_cnt-1; after the last write -> DONE; DONE asserts clr_done one cycle -> IDLE.
REQ-021 clr_busy is high in CLEAR and DONE; t_gnt is 0 in CLEAR; in IDLE and DONE, t_req is granted the same cycle.
REQ-022 Tile read granted in cycle N -> t_rvalid=1 and t_rdata=sa_rdata in cycle N+1; tile writes produce no t_rvalid.
REQ-023 Narrow port: round-robin between CPU and DMA; sole requester granted; on tie, the one not granted last wins; at most one gnt per cycle.
REQ-024 Conflict: port A active this cycle and candidate row (addr[ADDR_W_B-1:log2(WPR)]) equals sa_addr and (sa_we or candidate we) -> both narrow grants 0, arbitration pointer unchanged, conflict_cnt +1 (saturates at 16'hFFFF); read/read on same row is not a conflict.
REQ-025 Narrow read granted in cycle N -> winner's rvalid=1 and rdata=sb_rdata in cycle N+1; loser's rvalid stays 0; rdata ports hold last value.
REQ-026 sa_ce/sb_ce are high only in cycles with a grant or clear write; otherwise 0.

Reset
REQ-027 rst_n low: FSM IDLE, all outputs 0, conflict_cnt 0, round-robin pointer "last=DMA" (CPU wins first tie), pending rvalid tags cleared.
REQ-028 Reset during CLEAR abandons the clear without clr_done; remaining rows are not written.

Structure
REQ-029 Package mp64_sram_pkg holds default widths, WPR, clear FSM state encoding, conflict counter width.
REQ-030 Sub-module mp64_rr_arb2 (2-way round-robin with hold input) implements the narrow arbitration.

Verification
REQ-031 Tile write row 3 = {8 x 64'hCAFE_0000_0000_000w}, read row 3 -> t_rvalid next cycle, t_rdata equal.
REQ-032 CPU and DMA request reads simultaneously for 4 cycles -> grants C,D,C,D; rvalid routed to matching requester one cycle later.
REQ-033 Tile writes row 1 while CPU reads word {1,5} -> c_gnt 0 that cycle, conflict_cnt=1, CPU granted next cycle reading new data.
REQ-034 clr_start, clr_row=14, clr_cnt=4 -> rows 14,15,0,1 zeroed over 4 cycles, t_gnt 0 throughout, clr_done pulse cycle 5.
REQ-035 clr_cnt=0 -> clr_done one cycle later, no sa_ce; reset asserted mid-clear -> clr_busy 0, no clr_done, unwritten rows retain data.
